// File: rtl/arm_pkg.sv
// Shared definitions for the EXE-stage hazard/forwarding logic.
//   FWD_*        encodings of the EXE operand-mux selects
//   REG_IDX_W    width of an architectural register index
//   stage_tag_t  register tag carried by a pipeline stage
package arm_pkg;

  localparam int REG_IDX_W = 4;

  // FWD_EXE selects the ALU result that now sits in MEM.
  // FWD_MEM selects the memory-stage result that now sits in WB.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EXE = 2'b10;

  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] dest;
    logic                 wb;
    logic                 mr;
  } stage_tag_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Priority forwarding compare for one EXE operand.
//   en        operand is valid and read, and forwarding is enabled
//   src       register index read by the EX instruction
//   mem_act   MEM stage holds a valid, writing instruction
//   mem_dest  MEM stage destination index
//   wb_act    WB stage holds a valid, writing instruction
//   wb_dest   WB stage destination index
//   sel       operand mux select (FWD_RF / FWD_MEM / FWD_EXE)
module fwd_select
  import arm_pkg::*;
(
  input  logic                 en,
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 mem_act,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 wb_act,
  input  logic [REG_IDX_W-1:0] wb_dest,
  output logic [1:0]           sel
);

  // The MEM stage holds the newer value, so it wins when both stages match.
  always_comb begin
    sel = FWD_RF;
    if (en) begin
      if (mem_act && (mem_dest == src)) begin
        sel = FWD_EXE;
      end else if (wb_act && (wb_dest == src)) begin
        sel = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller between ID and EXE. Shadows the register tags of the
// EX, MEM and WB stages and derives operand forwarding, load-use stall,
// branch flush and saturating stall/flush counters.
//   clk, rst        clock; asynchronous active-low reset
//   id_*            decode fields of the instruction currently in ID
//   branch_taken    EX instruction redirects the PC this cycle
//   forward1/2      EXE operand mux selects
//   stall           hold PC and IF/ID, bubble into ID/EX
//   flush           clear IF/ID and ID/EX this edge
//   stall_cnt       saturating count of stall cycles
//   flush_cnt       saturating count of flush cycles
module hazard_fwd_ctrl
  import arm_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 id_wb_en,
  input  logic                 id_mem_read,
  input  logic                 branch_taken,
  output logic [1:0]           forward1,
  output logic [1:0]           forward2,
  output logic                 stall,
  output logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic FWD_ON = (FWD_EN != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // EX stage carries its source tags too, since forwarding is resolved there.
  stage_tag_t           ex_q, ex_d;
  logic [REG_IDX_W-1:0] ex_src1_q, ex_src1_d;
  logic [REG_IDX_W-1:0] ex_src2_q, ex_src2_d;
  logic                 ex_two_q, ex_two_d;

  // Past EX only the write-back tag matters; load status no longer affects anything.
  logic                 mem_v_q, mem_v_d;
  logic                 mem_wb_q, mem_wb_d;
  logic [REG_IDX_W-1:0] mem_dest_q, mem_dest_d;
  logic                 wb_v_q, wb_v_d;
  logic                 wb_wb_q, wb_wb_d;
  logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;

  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

  logic                 ex_hit1, ex_hit2, mem_hit, raw_hit;

  // Forwarding selects
  fwd_select u_fwd1 (
    .en       (FWD_ON && ex_q.v),
    .src      (ex_src1_q),
    .mem_act  (mem_v_q && mem_wb_q),
    .mem_dest (mem_dest_q),
    .wb_act   (wb_v_q && wb_wb_q),
    .wb_dest  (wb_dest_q),
    .sel      (forward1)
  );

  fwd_select u_fwd2 (
    .en       (FWD_ON && ex_q.v && ex_two_q),
    .src      (ex_src2_q),
    .mem_act  (mem_v_q && mem_wb_q),
    .mem_dest (mem_dest_q),
    .wb_act   (wb_v_q && wb_wb_q),
    .wb_dest  (wb_dest_q),
    .sel      (forward2)
  );

  // Stall / flush decision from shadow state and ID fields
  always_comb begin
    ex_hit1 = ex_q.v && ex_q.wb && (ex_q.dest == id_src1);
    ex_hit2 = ex_q.v && ex_q.wb && id_two_src && (ex_q.dest == id_src2);
    mem_hit = mem_v_q && mem_wb_q &&
              ((mem_dest_q == id_src1) || (id_two_src && (mem_dest_q == id_src2)));
    if (FWD_ON) begin
      // Only a load in EX cannot be forwarded in time.
      raw_hit = ex_q.mr && (ex_hit1 || ex_hit2);
    end else begin
      // WB is excluded: the register file writes in the first half-cycle.
      raw_hit = ex_hit1 || ex_hit2 || mem_hit;
    end
    flush = branch_taken;
    // A flush discards the ID instruction anyway, so it overrides the stall.
    stall = id_valid && raw_hit && !branch_taken;
  end

  // Next shadow state and counters
  always_comb begin
    ex_d      = ex_q;
    ex_src1_d = ex_src1_q;
    ex_src2_d = ex_src2_q;
    ex_two_d  = ex_two_q;
    if (stall || flush) begin
      ex_d.v = 1'b0;
    end else begin
      ex_d.v    = id_valid;
      ex_d.dest = id_dest;
      ex_d.wb   = id_wb_en;
      ex_d.mr   = id_mem_read;
      ex_src1_d = id_src1;
      ex_src2_d = id_src2;
      ex_two_d  = id_two_src;
    end
    mem_v_d     = ex_q.v;
    mem_wb_d    = ex_q.wb;
    mem_dest_d  = ex_q.dest;
    wb_v_d      = mem_v_q;
    wb_wb_d     = mem_wb_q;
    wb_dest_d   = mem_dest_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // State register: reset clears only the control bits; tags are don't-care while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q.v      <= 1'b0;
      ex_q.wb     <= 1'b0;
      ex_q.mr     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_wb_q    <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_wb_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_src1_q   <= ex_src1_d;
      ex_src2_q   <= ex_src2_d;
      ex_two_q    <= ex_two_d;
      mem_v_q     <= mem_v_d;
      mem_wb_q    <= mem_wb_d;
      mem_dest_q  <= mem_dest_d;
      wb_v_q      <= wb_v_d;
      wb_wb_q     <= wb_wb_d;
      wb_dest_q   <= wb_dest_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = '0;
  logic [3:0] id_src2 = '0;
  logic       id_two_src = 1'b0;
  logic [3:0] id_dest = '0;
  logic       id_wb_en = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       branch_taken = 1'b0;

  logic [1:0]  a_f1, a_f2, b_f1, b_f2, c_f1, c_f2;
  logic        a_st, a_fl, b_st, b_fl, c_st, c_fl;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0]  c_sc, c_fc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: forwarding, 16-bit counters; b: no forwarding; c: forwarding, 4-bit counters
  hazard_fwd_ctrl #(.FWD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .forward1(a_f1), .forward2(a_f2), .stall(a_st), .flush(a_fl),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  hazard_fwd_ctrl #(.FWD_EN(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .forward1(b_f1), .forward2(b_f2), .stall(b_st), .flush(b_fl),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  hazard_fwd_ctrl #(.FWD_EN(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .forward1(c_f1), .forward2(c_f2), .stall(c_st), .flush(c_fl),
    .stall_cnt(c_sc), .flush_cnt(c_fc));

  typedef struct {
    logic        v;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        two;
    logic [3:0]  d;
    logic        wb;
    logic        mr;
    logic        br;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic        st;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mkv(int v, int s1, int s2, int two, int d, int wb, int mr, int br,
                               int f1, int f2, int st, int fl, int sc, int fc);
    vec_t r;
    r.v = v[0]; r.s1 = s1[3:0]; r.s2 = s2[3:0]; r.two = two[0]; r.d = d[3:0];
    r.wb = wb[0]; r.mr = mr[0]; r.br = br[0];
    r.f1 = f1[1:0]; r.f2 = f2[1:0]; r.st = st[0]; r.fl = fl[0];
    r.sc = sc[15:0]; r.fc = fc[15:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic [3:0] d, input logic wb,
                       input logic mr, input logic br);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_read = mr; branch_taken = br;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    nop();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Load r5 ; dependent add r6,r5,r0
  task automatic drv_ldr();
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic drv_use();
    drive(1'b1, 4'd5, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle-by-cycle stream for the forwarding instance
    vecs[0]  = mkv(1, 2, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0); // ADD r1,r2,r3
    vecs[1]  = mkv(1, 1, 3, 1, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0); // SUB r2,r1,r3
    vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0); // SUB in EX: fwd1=10
    vecs[3]  = mkv(1, 2, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0); // ADD r1
    vecs[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0); // ADD reads r2 from WB (SUB)
    vecs[5]  = mkv(1, 1, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0); // ORR r4,r1,r1
    vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0); // ORR in EX: 01/01
    vecs[7]  = mkv(1, 2, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0, 0); // LDR r5
    vecs[8]  = mkv(1, 5, 0, 1, 6, 1, 0, 0,  0, 0, 1, 0, 0, 0); // ADD r6,r5,r0 stalls
    vecs[9]  = mkv(1, 5, 0, 1, 6, 1, 0, 0,  0, 0, 0, 0, 1, 0); // held, resolves
    vecs[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0); // ADD in EX: fwd1=01
    vecs[11] = mkv(1, 2, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 1, 0); // LDR r5
    vecs[12] = mkv(1, 5, 0, 1, 6, 1, 0, 1,  0, 0, 0, 1, 1, 0); // load-use + branch
    vecs[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1); // EX is a bubble
    vecs[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
    vecs[15] = mkv(1, 2, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 1, 1); // LDR r5
    vecs[16] = mkv(0, 5, 5, 1, 6, 1, 0, 0,  0, 0, 0, 0, 1, 1); // invalid ID never stalls
    vecs[17] = mkv(1, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0, 1, 1); // ADD r15
    vecs[18] = mkv(1, 15, 15, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1); // reads r15,r15
    vecs[19] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0, 1, 1); // both from MEM

    // Reset state, with a matching-looking ID instruction present
    #3;
    rst = 1'b0;
    drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    #4;
    chk("rst_stall", 32'(a_st), 32'd0);
    chk("rst_fwd1", 32'(a_f1), 32'd0);
    chk("rst_fwd2", 32'(a_f2), 32'd0);
    chk("rst_flush", 32'(a_fl), 32'd0);
    chk("rst_scnt", 32'(a_sc), 32'd0);
    chk("rst_fcnt", 32'(a_fc), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nop();
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].two, vecs[i].d,
            vecs[i].wb, vecs[i].mr, vecs[i].br);
      @(negedge clk);
      chk($sformatf("v%0d_fwd1", i), 32'(a_f1), 32'(vecs[i].f1));
      chk($sformatf("v%0d_fwd2", i), 32'(a_f2), 32'(vecs[i].f2));
      chk($sformatf("v%0d_stall", i), 32'(a_st), 32'(vecs[i].st));
      chk($sformatf("v%0d_flush", i), 32'(a_fl), 32'(vecs[i].fl));
      chk($sformatf("v%0d_scnt", i), 32'(a_sc), 32'(vecs[i].sc));
      chk($sformatf("v%0d_fcnt", i), 32'(a_fc), 32'(vecs[i].fc));
      @(posedge clk);
      #1;
    end

    // No forwarding: ADD r1 then MOV r2,r1 stalls two cycles
    do_reset();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("nf_c0_stall", 32'(b_st), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 4'd0, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("nf_c1_stall", 32'(b_st), 32'd1);
    chk("nf_c1_fwd", 32'({b_f1, b_f2}), 32'd0);
    chk("fw_c1_stall", 32'(a_st), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nf_c2_stall", 32'(b_st), 32'd1);
    chk("nf_c2_fwd", 32'({b_f1, b_f2}), 32'd0);
    chk("fw_c2_fwd2", 32'(a_f2), 32'd2);
    chk("fw_c2_fwd1", 32'(a_f1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nf_c3_stall", 32'(b_st), 32'd0);
    chk("nf_c3_fwd", 32'({b_f1, b_f2}), 32'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    chk("nf_c4_fwd", 32'({b_f1, b_f2}), 32'd0);
    chk("nf_c4_scnt", 32'(b_sc), 32'd2);
    @(posedge clk); #1;

    // Counter saturation
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drv_ldr();
      @(posedge clk); #1;
      drv_use();
      @(negedge clk);
      chk($sformatf("sat_stall_%0d", k), 32'(c_st), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (k == 15) begin
        chk("sat_c_scnt15", 32'(c_sc), 32'd15);
      end
    end
    chk("sat_c_scnt_hold", 32'(c_sc), 32'd15);
    chk("sat_a_scnt20", 32'(a_sc), 32'd20);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
    end
    chk("sat_c_fcnt_hold", 32'(c_fc), 32'd15);
    chk("sat_a_fcnt18", 32'(a_fc), 32'd18);

    // Asynchronous reset in the middle of a stall
    drv_ldr();
    @(posedge clk); #1;
    drv_use();
    @(negedge clk);
    chk("mid_pre_stall", 32'(c_st), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_stall", 32'(c_st), 32'd0);
    chk("mid_c_scnt", 32'(c_sc), 32'd0);
    chk("mid_c_fcnt", 32'(c_fc), 32'd0);
    chk("mid_a_scnt", 32'(a_sc), 32'd0);
    chk("mid_a_stall", 32'(a_st), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nop();
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
